stdp_update_scheduler: RTL and testbench

//  Watches NUM_PRE presynaptic spike lines and one postsynaptic spike line.

---
 rtl/stdp_update_scheduler_if.sv | 35 +++
 rtl/stdp_update_scheduler.sv | 165 ++++++++++++++++
 tb/tb_stdp_update_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_update_scheduler_if.sv
// Weight-update request channel between the STDP scheduler and the shared
// weight-update unit.
//   upd_valid  request valid (scheduler -> weight unit)
//   upd_ready  weight unit accepts the request this cycle
//   upd_idx    presynaptic index to update
//   upd_ltp    1 = potentiate, 0 = depress
//   upd_dt     spike-time difference in cycles
interface stdp_update_scheduler_if #(
  parameter int NUM_PRE = 4,
  parameter int TW      = 8
);
  localparam int IW = $clog2(NUM_PRE);

  logic          upd_valid;
  logic          upd_ready;
  logic [IW-1:0] upd_idx;
  logic          upd_ltp;
  logic [TW-1:0] upd_dt;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_ltp,
    output upd_dt,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_ltp,
    input  upd_dt,
    output upd_ready
  );
endinterface

// File: rtl/stdp_update_scheduler.sv
// STDP update scheduler.
// Tracks time since the last spike on each presynaptic line and on the
// postsynaptic line, turns pairings inside the STDP window into LTP/LTD
// requests, and issues them round-robin, one per cycle at most, to a single
// shared weight-update unit.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   pre_spike   NUM_PRE one-cycle presynaptic spike pulses
//   post_spike  one-cycle postsynaptic spike pulse
//   upd         request channel (master side): valid/ready, idx, ltp, dt
//   busy        a request is pending or upd_valid is high (combinational)
//   ovw_cnt     saturating count of pending requests that were overwritten
module stdp_update_scheduler #(
  parameter int NUM_PRE = 4,
  parameter int TW      = 8,
  parameter int WINDOW  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PRE-1:0]             pre_spike,
  input  logic                           post_spike,
  stdp_update_scheduler_if.master        upd,
  output logic                           busy,
  output logic [7:0]                     ovw_cnt
);

  localparam int NS = 2 * NUM_PRE;
  localparam int SW = $clog2(NS);
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};
  localparam logic [TW:0]   WIN  = (TW+1)'(WINDOW);

  typedef enum logic {IDLE, ISSUE} state_t;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t == TMAX) ? TMAX : t + TW'(1);
  endfunction

  function automatic logic in_window(input logic [TW-1:0] dt);
    return {1'b0, dt} < WIN;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [SW:0] n);
    logic [8:0] sum;
    sum = {1'b0, cnt} + 9'(n);
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

  logic [TW-1:0] pre_t [NUM_PRE];
  logic [TW-1:0] post_t;
  logic [NS-1:0] pend;
  logic [TW-1:0] slot_dt [NS];
  logic [SW-1:0] rr_ptr;
  state_t        state;

  logic [NS-1:0] set_vec;
  logic [TW-1:0] set_dt [NS];
  logic          found;
  logic [SW-1:0] gnt;
  int            s;
  logic          grant_en;
  logic [NS-1:0] clr_vec;
  logic [NS-1:0] ovw_vec;
  logic [SW:0]   n_ovw;

  // Event capture: slot 2i holds LTP of input i, slot 2i+1 holds LTD of input i.
  // dt is the pre-edge timer plus one, so a spike one edge earlier gives dt=1.
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      set_dt[2*i]   = pre_spike[i] ? '0 : sat_inc(pre_t[i]);
      set_dt[2*i+1] = sat_inc(post_t);
      if (post_spike)
        set_vec[2*i] = pre_spike[i] || in_window(set_dt[2*i]);
      else
        set_vec[2*i+1] = pre_spike[i] && in_window(set_dt[2*i+1]);
    end
  end

  // Round-robin pick: walking the offsets downwards leaves the smallest
  // offset from rr_ptr as the winner without needing an early exit.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    s     = 0;
    for (int k = NS - 1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= NS) s = s - NS;
      if (pend[s]) begin
        found = 1'b1;
        gnt   = SW'(s);
      end
    end
  end

  assign grant_en = found && ((state == IDLE) || !upd.upd_valid || upd.upd_ready);
  assign clr_vec  = grant_en ? (NS'(1) << gnt) : '0;

  // A slot granted on this edge is leaving, so a new event for it starts a
  // fresh request rather than overwriting one.
  assign ovw_vec = set_vec & pend & ~clr_vec;

  always_comb begin
    n_ovw = '0;
    for (int j = 0; j < NS; j++) n_ovw = n_ovw + (SW+1)'(ovw_vec[j]);
  end

  assign busy = upd.upd_valid | (|pend);

  // Stored dt per slot is only meaningful while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NS; j++)
      if (set_vec[j]) slot_dt[j] <= set_dt[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRE; i++) pre_t[i] <= TMAX;
      post_t        <= TMAX;
      pend          <= '0;
      rr_ptr        <= '0;
      state         <= IDLE;
      ovw_cnt       <= '0;
      upd.upd_valid <= 1'b0;
      upd.upd_idx   <= '0;
      upd.upd_ltp   <= 1'b0;
      upd.upd_dt    <= '0;
    end else begin
      for (int i = 0; i < NUM_PRE; i++)
        pre_t[i] <= pre_spike[i] ? '0 : sat_inc(pre_t[i]);
      post_t  <= post_spike ? '0 : sat_inc(post_t);
      // Set wins over the grant clear on the same edge.
      pend    <= (pend & ~clr_vec) | set_vec;
      ovw_cnt <= sat_add8(ovw_cnt, n_ovw);

      case (state)
        IDLE: begin
          if (grant_en) begin
            upd.upd_valid <= 1'b1;
            upd.upd_idx   <= gnt[SW-1:1];
            upd.upd_ltp   <= ~gnt[0];
            upd.upd_dt    <= slot_dt[gnt];
            rr_ptr        <= (gnt == SW'(NS-1)) ? '0 : gnt + SW'(1);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!upd.upd_valid || upd.upd_ready) begin
            if (grant_en) begin
              upd.upd_valid <= 1'b1;
              upd.upd_idx   <= gnt[SW-1:1];
              upd.upd_ltp   <= ~gnt[0];
              upd.upd_dt    <= slot_dt[gnt];
              rr_ptr        <= (gnt == SW'(NS-1)) ? '0 : gnt + SW'(1);
            end else begin
              upd.upd_valid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stdp_update_scheduler.sv
module tb_stdp_update_scheduler;
  localparam int NP  = 4;
  localparam int TW  = 8;
  localparam int WIN = 16;
  localparam int NS  = 2 * NP;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pre_spike;
  logic          post_spike;
  logic          busy;
  logic [7:0]    ovw_cnt;

  stdp_update_scheduler_if #(.NUM_PRE(NP), .TW(TW)) upd_if ();

  stdp_update_scheduler #(.NUM_PRE(NP), .TW(TW), .WINDOW(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .upd        (upd_if),
    .busy       (busy),
    .ovw_cnt    (ovw_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct { int cyc; int idx; bit ltp; int dt; } xfer_t;
  xfer_t xfers[$];

  // Reference model: spike timestamps instead of timers, a pending table
  // per (input, kind), and the request currently offered.
  int now;
  int last_pre [NP];
  int last_post;
  bit m_pend [NS];
  int m_pdt  [NS];
  int m_rr;
  bit m_valid;
  int m_idx;
  bit m_ltp;
  int m_dt;
  int m_ovw;

  function automatic int age(input int t_last);
    int d;
    if (t_last < 0) return 255;
    d = now - t_last;
    return (d > 255) ? 255 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) last_pre[i] = -1;
    last_post = -1;
    for (int j = 0; j < NS; j++) begin m_pend[j] = 0; m_pdt[j] = 0; end
    m_rr = 0; m_valid = 0; m_idx = 0; m_ltp = 0; m_dt = 0; m_ovw = 0;
  endtask

  task automatic model_edge(input logic [NP-1:0] pre, input logic post, input logic rdy);
    int g, slot, dt;
    bit fire;
    now++;
    if (!m_valid || rdy) begin
      g = -1;
      for (int k = 0; k < NS; k++)
        if (g < 0 && m_pend[(m_rr + k) % NS]) g = (m_rr + k) % NS;
      if (g >= 0) begin
        m_valid = 1; m_idx = g / 2; m_ltp = (g % 2 == 0); m_dt = m_pdt[g];
        m_pend[g] = 0; m_rr = (g + 1) % NS;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < NP; i++) begin
      fire = 0; slot = 0; dt = 0;
      if (post) begin
        slot = 2 * i; dt = pre[i] ? 0 : age(last_pre[i]); fire = (dt < WIN);
      end else if (pre[i]) begin
        slot = 2 * i + 1; dt = age(last_post); fire = (dt < WIN);
      end
      if (fire) begin
        if (m_pend[slot] && m_ovw < 255) m_ovw++;
        m_pend[slot] = 1; m_pdt[slot] = dt;
      end
    end
    for (int i = 0; i < NP; i++) if (pre[i]) last_pre[i] = now;
    if (post) last_post = now;
  endtask

  function automatic logic [20:0] model_vec();
    bit b;
    b = m_valid;
    for (int j = 0; j < NS; j++) if (m_pend[j]) b = 1;
    return {m_valid, 2'(m_idx), m_ltp, 8'(m_dt), b, 8'(m_ovw)};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {upd_if.upd_valid, upd_if.upd_idx, upd_if.upd_ltp, upd_if.upd_dt, busy, ovw_cnt};
  endfunction

  task automatic step(input logic [NP-1:0] pre, input logic post, input logic rdy);
    xfer_t x;
    pre_spike = pre; post_spike = post; upd_if.upd_ready = rdy;
    if (upd_if.upd_valid === 1'b1 && rdy) begin
      x.cyc = now; x.idx = int'(upd_if.upd_idx); x.ltp = upd_if.upd_ltp; x.dt = int'(upd_if.upd_dt);
      xfers.push_back(x);
    end
    model_edge(pre, post, rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pre_spike = NP'($urandom); post_spike = 1'b1; upd_if.upd_ready = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; pre_spike = '0; post_spike = 1'b0;
    model_reset();
    xfers.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pre_spike = NP'($urandom); post_spike = 1'b1; upd_if.upd_ready = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (dut_vec() !== 21'd0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 21'd0);
    end
    rst = 1'b0; pre_spike = '0; post_spike = 1'b0;
    model_reset(); xfers.delete();
    for (int c = 0; c < 20; c++) begin
      step('0, 1'b0, 1'b1);
      checks++;
      if ({upd_if.upd_valid, busy, ovw_cnt} !== 10'd0) begin
        failures++; $display("FAIL reset_quiet c=%0d got=%b/%b/%0d exp=0/0/0", c, upd_if.upd_valid, busy, ovw_cnt);
      end
    end
  endtask

  task automatic test_ltp_pair();
    do_reset();
    step(4'b0100, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step('0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL ltp_pair_cycle c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (xfers.size() != 1 || xfers[0].idx != 2 || xfers[0].ltp != 1 || xfers[0].dt != 5) begin
      failures++;
      $display("FAIL ltp_pair_req n=%0d first={%0d,%0d,%0d} exp n=1 {2,1,5}", xfers.size(),
               (xfers.size() > 0) ? xfers[0].idx : -1, (xfers.size() > 0) ? xfers[0].ltp : 0,
               (xfers.size() > 0) ? xfers[0].dt : -1);
    end
  endtask

  task automatic test_ltd_window();
    do_reset();
    step('0, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) step('0, 1'b0, 1'b1);
    checks++;
    if (xfers.size() != 1 || xfers[0].idx != 1 || xfers[0].ltp != 0 || xfers[0].dt != 3) begin
      failures++;
      $display("FAIL ltd_pair_req n=%0d first={%0d,%0d,%0d} exp n=1 {1,0,3}", xfers.size(),
               (xfers.size() > 0) ? xfers[0].idx : -1, (xfers.size() > 0) ? xfers[0].ltp : 0,
               (xfers.size() > 0) ? xfers[0].dt : -1);
    end
    do_reset();
    step('0, 1'b1, 1'b1);
    for (int c = 0; c < 15; c++) step('0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step('0, 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b0) begin
        failures++; $display("FAIL ltd_gap16_busy c=%0d got=%b exp=0", c, busy);
      end
    end
    checks++;
    if (xfers.size() != 0) begin
      failures++; $display("FAIL ltd_gap16_req got=%0d requests exp=0", xfers.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(4'b1111, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step('0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL b2b_cycle c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (xfers.size() != 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", xfers.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (xfers[k].idx != k || xfers[k].ltp != 1 || xfers[k].dt != 3 || xfers[k].cyc != xfers[0].cyc + k) begin
          failures++;
          $display("FAIL b2b_req k=%0d got={%0d,%0d,%0d,+%0d} exp={%0d,1,3,+%0d}", k, xfers[k].idx,
                   xfers[k].ltp, xfers[k].dt, xfers[k].cyc - xfers[0].cyc, k, k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(4'b0111, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step('0, 1'b0, 1'b0);
      checks++;
      if ({upd_if.upd_valid, upd_if.upd_idx, upd_if.upd_ltp, upd_if.upd_dt, busy} !== {1'b1, 2'd0, 1'b1, 8'd1, 1'b1}) begin
        failures++;
        $display("FAIL hold_stable c=%0d got=%b/%0d/%b/%0d exp=1/0/1/1", c, upd_if.upd_valid,
                 upd_if.upd_idx, upd_if.upd_ltp, upd_if.upd_dt);
      end
    end
    for (int c = 0; c < 5; c++) begin
      step('0, 1'b0, 1'b1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL drain_cycle c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (xfers.size() != 3 || busy !== 1'b0) begin
      failures++; $display("FAIL drain_done got n=%0d busy=%b exp n=3 busy=0", xfers.size(), busy);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (xfers[k].idx != k || xfers[k].ltp != 1 || xfers[k].dt != 1) begin
          failures++; $display("FAIL drain_req k=%0d got={%0d,%0d,%0d} exp={%0d,1,1}", k,
                               xfers[k].idx, xfers[k].ltp, xfers[k].dt, k);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    step(4'b0001, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b1);
    checks++;
    if (xfers.size() != 1 || xfers[0].idx != 0 || xfers[0].ltp != 1 || xfers[0].dt != 0) begin
      failures++;
      $display("FAIL same_edge_req n=%0d first={%0d,%0d,%0d} exp n=1 {0,1,0}", xfers.size(),
               (xfers.size() > 0) ? xfers[0].idx : -1, (xfers.size() > 0) ? xfers[0].ltp : 0,
               (xfers.size() > 0) ? xfers[0].dt : -1);
    end
    // Keep an unrelated LTD request in flight so the LTP slot stays pending.
    do_reset();
    step('0, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    for (int c = 0; c < 17; c++) step('0, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) step('0, 1'b0, 1'b0);
    checks++;
    if (ovw_cnt !== 8'd0) begin
      failures++; $display("FAIL ovw_before got=%0d exp=0", ovw_cnt);
    end
    step('0, 1'b1, 1'b0);
    checks++;
    if (ovw_cnt !== 8'd1) begin
      failures++; $display("FAIL ovw_after got=%0d exp=1", ovw_cnt);
    end
    for (int c = 0; c < 4; c++) step('0, 1'b0, 1'b1);
    checks++;
    if (xfers.size() != 2 || xfers[0].idx != 1 || xfers[0].ltp != 0 || xfers[0].dt != 3 ||
        xfers[1].idx != 0 || xfers[1].ltp != 1 || xfers[1].dt != 3) begin
      failures++;
      $display("FAIL ovw_reqs n=%0d last={%0d,%0d,%0d} exp n=2 {1,0,3},{0,1,3}", xfers.size(),
               (xfers.size() > 0) ? xfers[xfers.size()-1].idx : -1,
               (xfers.size() > 0) ? xfers[xfers.size()-1].ltp : 0,
               (xfers.size() > 0) ? xfers[xfers.size()-1].dt : -1);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] pre;
    logic post, rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) pre[i] = ($urandom_range(7) == 0);
      post = ($urandom_range(5) == 0);
      rdy  = (c < 300) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
      step(pre, post, rdy);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random_cycle c=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; pre_spike = '0; post_spike = 1'b0; upd_if.upd_ready = 1'b0;
    now = 0;
    model_reset();
    test_reset();
    test_ltp_pair();
    test_ltd_window();
    test_back_to_back();
    test_backpressure();
    test_same_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
